m_sprite_renderer: RTL
======================

Name: m_sprite_renderer

Overview:
- Display-side consumer of the game-logic outputs.
- Each frame it takes the player and ghost cell positions and erases each sprite's previous 5x5 cell by restoring pixels from background memory. It then draws each sprite's new 5x5 cell and drives the VGA adapter plot interface.
- It also queues background pixel write requests (bg_x/bg_y/bg_color/bg_wren), such as eaten-food dots, and plots them between frames.

Parameters:
- PLAYER_COLOR, 3'b110, player sprite colour
- G1_COLOR, 3'b100, ghost 1 colour
- G2_COLOR, 3'b101, ghost 2 colour
- G3_COLOR, 3'b011, ghost 3 colour
- FIFO_DEPTH, 4, background-request queue entries (power of 2)

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  start-frame pulse
- player_x  in  5  player cell column
- player_y  in  4  player cell row
- ghost1_x/ghost2_x/ghost3_x  in  5 each  ghost cell columns
- ghost1_y/ghost2_y/ghost3_y  in  4 each  ghost cell rows
- bg_x  in  8  background request pixel x
- bg_y  in  7  background request pixel y
- bg_color  in  3  background request colour
- bg_wren  in  1  background request strobe, one request per cycle high
- bg_rd_addr  out  15  background memory read address, = y*160 + x
- bg_rd_data  in  3  background memory data, valid one cycle after address
- vga_x  out  8  plot x
- vga_y  out  7  plot y
- vga_color  out  3  plot colour
- vga_plot  out  1  plot strobe
- finished  out  1  one-cycle pulse at end of frame
- overflow  out  1  sticky, set when a request is dropped because the queue is full

Behaviour:
- Reset (async, resetn=0):
  - State IDLE; all outputs 0; queue empty; pending=0; first_frame=1; stored old positions 0.
  - vga_plot drops to 0 immediately, including mid-frame.
- Pixel mapping: px = cell_x*5 + dx, py = cell_y*5 + dy, with dx,dy in 0..4 scanned dx-fastest. Max values are 159 and 79; no overflow.
- enable sampled every cycle:
  - Sets pending in any state.
  - A second enable while pending is absorbed.
- Request queue:
  - Push when bg_wren=1, in any state.
  - Full and no pop in that cycle: request dropped, overflow<=1.
  - Push and pop in the same cycle when full: push accepted.
- States:
  - IDLE:
    - If queue non-empty: pop one entry per cycle and plot it (vga_x/y/color = entry, vga_plot=1). The entry is plotted in the same cycle as the pop.
    - Else if pending: latch all 8 position inputs as new positions, clear pending, go to ERASE (or DRAW if first_frame=1).
  - ERASE: for sprites in order player, g1, g2, g3, use the old position.
    - Cycle k presents bg_rd_addr for pixel k.
    - Cycle k+1 plots pixel k with colour bg_rd_data.
    - 26 cycles per sprite; 104 cycles total.
  - DRAW: for sprites in order g1, g2, g3, player (player drawn last so it is on top).
    - One plot per cycle in the sprite's colour parameter.
    - 25 cycles per sprite; 100 cycles total.
  - DONE:
    - finished=1 for one cycle.
    - Copy new positions to old positions; first_frame<=0.
    - Return to IDLE.
- The queue is never drained during ERASE or DRAW.
- vga_plot=0 in any cycle not listed above as a plot cycle.
- Positions are latched at frame start; input changes mid-frame have no effect.

Optional Feature:
- Macro: SPRITE_SHAPE_EN.
- Defined: DRAW skips the four corner pixels (dx,dy both in {0,4}). No plot occurs in those cycles, but the cycle count is unchanged (25 per sprite), giving rounded sprites. ERASE still restores all 25 pixels.
- Undefined: full 5x5 squares are drawn.

Test Plan:
- Reset, then enable with player=(1,1), ghosts (3,2),(5,2),(7,2); bg_rd_data irrelevant → no erase; exactly 100 plots; first player plot at (5,5) colour 3'b110; last plot at (9,9); finished pulses once.
- Second frame with player moved to (2,1), bg_rd_data held at 3'b001 → 104 erase cycles; first erase plot (5,5) colour 3'b001, seen one cycle after bg_rd_addr=805; then 100 draw plots; player drawn at x 10..14.
- Six bg_wren pulses issued during DRAW (FIFO_DEPTH=4) → 4 entries plotted in IDLE in push order after finished; overflow=1; the other 2 requests are never plotted.
- enable asserted while the queue holds 2 entries → the 2 entries are plotted first, then the frame starts; pending stays set across the drain.
- resetn pulsed low at DRAW cycle 40 → vga_plot=0 and finished=0 immediately; the next enable behaves as a first frame (no erase).
- SPRITE_SHAPE_EN defined, first frame → 84 plots; none at (5,5),(9,5),(5,9),(9,9); finished at the same cycle as the undefined build.

Source files
------------

// File: rtl/m_sprite_renderer.sv
// m_sprite_renderer: per frame, erases four 5x5 sprite cells by restoring
// pixels from background memory, then redraws them at their new cells.
// Queued background write requests are plotted while idle between frames.
// Optional feature: define SPRITE_SHAPE_EN to skip the four corner pixels
// when drawing (rounded sprites, same cycle count).
module m_sprite_renderer #(
  parameter logic [2:0] PLAYER_COLOR = 3'b110,
  parameter logic [2:0] G1_COLOR     = 3'b100,
  parameter logic [2:0] G2_COLOR     = 3'b101,
  parameter logic [2:0] G3_COLOR     = 3'b011,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        enable,
  input  logic [4:0]  player_x,
  input  logic [3:0]  player_y,
  input  logic [4:0]  ghost1_x,
  input  logic [4:0]  ghost2_x,
  input  logic [4:0]  ghost3_x,
  input  logic [3:0]  ghost1_y,
  input  logic [3:0]  ghost2_y,
  input  logic [3:0]  ghost3_y,
  input  logic [7:0]  bg_x,
  input  logic [6:0]  bg_y,
  input  logic [2:0]  bg_color,
  input  logic        bg_wren,
  output logic [14:0] bg_rd_addr,
  input  logic [2:0]  bg_rd_data,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_color,
  output logic        vga_plot,
  output logic        finished,
  output logic        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ERASE = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  spr_q, spr_d;
  logic [2:0]  dx_q, dx_d, dy_q, dy_d;
  logic        pending_q, pending_d;
  logic        first_q, first_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  prev_x_q;
  logic [6:0]  prev_y_q;
  logic [4:0]  new_x_q [4];
  logic [3:0]  new_y_q [4];
  logic [4:0]  old_x_q [4];
  logic [3:0]  old_y_q [4];
  logic [17:0] fifo_q [FIFO_DEPTH];
  logic [PW:0] wr_q, rd_q;

  logic        empty, full, push, pop, start, corner;
  logic [1:0]  sel;
  logic [4:0]  cell_x;
  logic [3:0]  cell_y;
  logic [7:0]  cur_x;
  logic [6:0]  cur_y;
  logic [14:0] rd_addr;

  // Index 0 is the player, 1..3 the ghosts.
  function automatic logic [2:0] sprite_color(input logic [1:0] idx);
    case (idx)
      2'd0:    sprite_color = PLAYER_COLOR;
      2'd1:    sprite_color = G1_COLOR;
      2'd2:    sprite_color = G2_COLOR;
      default: sprite_color = G3_COLOR;
    endcase
  endfunction

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign pop   = (state_q == S_IDLE) && !empty;
  assign push  = bg_wren && (!full || pop);
  assign start = (state_q == S_IDLE) && empty && pending_q;

  // Erase walks player,g1,g2,g3; draw walks g1,g2,g3,player so spr+1 wraps to player last.
  assign sel     = (state_q == S_DRAW) ? spr_q + 2'd1 : spr_q;
  assign cell_x  = (state_q == S_ERASE) ? old_x_q[sel] : new_x_q[sel];
  assign cell_y  = (state_q == S_ERASE) ? old_y_q[sel] : new_y_q[sel];
  assign cur_x   = 8'(cell_x) * 8'd5 + 8'(dx_q);
  assign cur_y   = 7'(cell_y) * 7'd5 + 7'(dy_q);
  assign rd_addr = 15'(cur_y) * 15'd160 + 15'(cur_x);
  assign corner  = (dx_q == 3'd0 || dx_q == 3'd4) && (dy_q == 3'd0 || dy_q == 3'd4);

  // Next-state: frame sequencing, dx-fastest pixel scan, pending and overflow flags.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    spr_d     = spr_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    pending_d = enable | (pending_q & ~start);
    first_d   = first_q;
    ovf_d     = ovf_q | (bg_wren & full & ~pop);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = first_q ? S_DRAW : S_ERASE;
          cnt_d   = 5'd0;
          spr_d   = 2'd0;
          dx_d    = 3'd0;
          dy_d    = 3'd0;
        end
      end
      S_ERASE: begin
        // Cycle 25 of each sprite only flushes the last read; the scan has already wrapped.
        if (cnt_q != 5'd25) begin
          dx_d = (dx_q == 3'd4) ? 3'd0 : dx_q + 3'd1;
          if (dx_q == 3'd4) dy_d = (dy_q == 3'd4) ? 3'd0 : dy_q + 3'd1;
        end
        if (cnt_q == 5'd25) begin
          cnt_d = 5'd0;
          spr_d = spr_q + 2'd1;
          if (spr_q == 2'd3) state_d = S_DRAW;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DRAW: begin
        dx_d = (dx_q == 3'd4) ? 3'd0 : dx_q + 3'd1;
        if (dx_q == 3'd4) dy_d = (dy_q == 3'd4) ? 3'd0 : dy_q + 3'd1;
        if (cnt_q == 5'd24) begin
          cnt_d = 5'd0;
          spr_d = spr_q + 2'd1;
          if (spr_q == 2'd3) state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        first_d = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from state so an async reset silences the plot strobe at once.
  always_comb begin
    bg_rd_addr = 15'd0;
    vga_x      = 8'd0;
    vga_y      = 7'd0;
    vga_color  = 3'd0;
    vga_plot   = 1'b0;
    finished   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          {vga_x, vga_y, vga_color} = fifo_q[rd_q[PW-1:0]];
          vga_plot = 1'b1;
        end
      end
      S_ERASE: begin
        if (cnt_q != 5'd25) bg_rd_addr = rd_addr;
        if (cnt_q != 5'd0) begin
          vga_x     = prev_x_q;
          vga_y     = prev_y_q;
          vga_color = bg_rd_data;
          vga_plot  = 1'b1;
        end
      end
      S_DRAW: begin
        vga_x     = cur_x;
        vga_y     = cur_y;
        vga_color = sprite_color(sel);
`ifdef SPRITE_SHAPE_EN
        vga_plot  = ~corner;
`else
        vga_plot  = 1'b1;
`endif
      end
      default: finished = 1'b1;
    endcase
  end

  assign overflow = ovf_q;

  // Control registers and queue pointers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      spr_q     <= 2'd0;
      dx_q      <= 3'd0;
      dy_q      <= 3'd0;
      pending_q <= 1'b0;
      first_q   <= 1'b1;
      ovf_q     <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      spr_q     <= spr_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      pending_q <= pending_d;
      first_q   <= first_d;
      ovf_q     <= ovf_d;
      if (push) wr_q <= wr_q + (PW+1)'(1);
      if (pop)  rd_q <= rd_q + (PW+1)'(1);
    end
  end

  // Sprite positions and the pixel whose memory read is in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        new_x_q[i] <= 5'd0;
        new_y_q[i] <= 4'd0;
        old_x_q[i] <= 5'd0;
        old_y_q[i] <= 4'd0;
      end
      prev_x_q <= 8'd0;
      prev_y_q <= 7'd0;
    end else begin
      if (start) begin
        new_x_q[0] <= player_x;  new_y_q[0] <= player_y;
        new_x_q[1] <= ghost1_x;  new_y_q[1] <= ghost1_y;
        new_x_q[2] <= ghost2_x;  new_y_q[2] <= ghost2_y;
        new_x_q[3] <= ghost3_x;  new_y_q[3] <= ghost3_y;
      end
      if (state_q == S_DONE) begin
        for (int i = 0; i < 4; i++) begin
          old_x_q[i] <= new_x_q[i];
          old_y_q[i] <= new_y_q[i];
        end
      end
      if (state_q == S_ERASE) begin
        prev_x_q <= cur_x;
        prev_y_q <= cur_y;
      end
    end
  end

  // Queue storage; emptiness is tracked by the pointers alone.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_q[PW-1:0]] <= {bg_x, bg_y, bg_color};
  end

endmodule
